// File: rtl/lbp_window_fetch_if.sv
// Handshake and memory-port bundle for the LBP 3x3 window fetcher.
// master = fetcher side, slave = environment (memory + downstream consumer).
interface lbp_window_fetch_if #(
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 7,
    parameter int DATA_W   = 8
);
    localparam int AW = COL_BITS + ROW_BITS;

    logic                start_i;
    logic                gray_req_o;
    logic [AW-1:0]       gray_addr_o;
    logic [DATA_W-1:0]   gray_data_i;
    logic                win_valid_o;
    logic                win_ready_i;
    logic [DATA_W-1:0]   center_o;
    logic [8*DATA_W-1:0] nbr_o;
    logic [AW-1:0]       pix_addr_o;
    logic                border_o;
    logic                done_o;

    modport master (
        input  start_i, gray_data_i, win_ready_i,
        output gray_req_o, gray_addr_o, win_valid_o, center_o, nbr_o,
               pix_addr_o, border_o, done_o
    );

    modport slave (
        output start_i, gray_data_i, win_ready_i,
        input  gray_req_o, gray_addr_o, win_valid_o, center_o, nbr_o,
               pix_addr_o, border_o, done_o
    );
endinterface

// File: rtl/lbp_window_fetch.sv
// Raster-scans the image, reads each interior pixel's 3x3 (or plus-shaped) neighbourhood and
// presents it as a window; CHECK->OUT takes 11/7/1 cycles, and OUT holds until win_ready_i.
module lbp_window_fetch #(
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 7,
    parameter int DATA_W   = 8,
    parameter int MODE     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    lbp_window_fetch_if.master bus
);
    localparam int              AW     = COL_BITS + ROW_BITS;
    localparam logic [3:0]      LAST_K = (MODE == 1) ? 4'd4 : 4'd8;
    localparam logic [AW-1:0]   ZERO   = '0;
    localparam logic [AW-1:0]   ONE    = AW'(1);
    localparam logic [AW-1:0]   W_OFF  = ONE << COL_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_FETCH, S_WAIT, S_OUT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       pix_q;
    logic [3:0]          k_q;
    logic [DATA_W-1:0]   win_q [9];
    logic                cap_vld_q;
    logic [3:0]          cap_slot_q;
    logic [3:0]          slot;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                is_border;
    logic                is_last;

    // Window slot 0 is the centre, slot n+1 holds neighbour n.
    function automatic logic [3:0] slot_of(input logic [3:0] kk);
        logic [3:0] s;
        s = kk;
        if (MODE == 1) begin
            case (kk)
                4'd1:    s = 4'd2;
                4'd2:    s = 4'd4;
                4'd3:    s = 4'd5;
                4'd4:    s = 4'd7;
                default: s = 4'd0;
            endcase
        end
        return s;
    endfunction

    function automatic logic [AW-1:0] offset_of(input logic [3:0] sl);
        logic [AW-1:0] o;
        case (sl)
            4'd1:    o = ZERO - W_OFF - ONE;
            4'd2:    o = ZERO - W_OFF;
            4'd3:    o = ZERO - W_OFF + ONE;
            4'd4:    o = ZERO - ONE;
            4'd5:    o = ONE;
            4'd6:    o = W_OFF - ONE;
            4'd7:    o = W_OFF;
            4'd8:    o = W_OFF + ONE;
            default: o = ZERO;
        endcase
        return o;
    endfunction

    assign col       = pix_q[COL_BITS-1:0];
    assign row       = pix_q[AW-1:COL_BITS];
    assign is_border = (row == '0) || (row == '1) || (col == '0) || (col == '1);
    assign is_last   = (pix_q == '1);
    assign slot      = slot_of(k_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.gray_req_o  = 1'b0;
        bus.gray_addr_o = '0;
        bus.win_valid_o = 1'b0;
        bus.border_o    = 1'b0;
        bus.done_o      = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_CHECK;
            S_CHECK: state_d = is_border ? S_OUT : S_FETCH;
            S_FETCH: begin
                bus.gray_req_o  = 1'b1;
                bus.gray_addr_o = pix_q + offset_of(slot);
                if (k_q == LAST_K) state_d = S_WAIT;
            end
            S_WAIT:  state_d = S_OUT;
            S_OUT: begin
                bus.win_valid_o = 1'b1;
                bus.border_o    = is_border;
                if (bus.win_ready_i) state_d = is_last ? S_DONE : S_CHECK;
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data arrives one cycle after its request, so the slot travels with a delayed strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q      <= '0;
            k_q        <= '0;
            cap_vld_q  <= 1'b0;
            cap_slot_q <= '0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            cap_vld_q  <= (state_q == S_FETCH);
            cap_slot_q <= slot;
            if (cap_vld_q) win_q[cap_slot_q] <= bus.gray_data_i;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        pix_q <= '0;
                        for (int i = 0; i < 9; i++) win_q[i] <= '0;
                    end
                end
                S_CHECK: begin
                    k_q <= '0;
                    for (int i = 0; i < 9; i++) win_q[i] <= '0;
                end
                S_FETCH: k_q <= k_q + 4'd1;
                S_OUT:   if (bus.win_ready_i && !is_last) pix_q <= pix_q + ONE;
                default: ;
            endcase
        end
    end

    assign bus.center_o   = win_q[0];
    assign bus.pix_addr_o = pix_q;

    for (genvar n = 0; n < 8; n++) begin : g_nbr
        assign bus.nbr_o[n*DATA_W +: DATA_W] = win_q[n+1];
    end
endmodule

// File: tb/tb_lbp_window_fetch.sv
// Bench for lbp_window_fetch: an 8x4 MODE 0 instance and a 4x8 MODE 1 instance scanned in turn
// against random memory contents, random backpressure and stray start pulses.
module tb_lbp_window_fetch;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ready;
    int         sel;
    logic [7:0] mem [0:31];
    int         n_vec = 0;
    int         n_err = 0;

    int dr [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
    int dc [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

    always #5 clk = ~clk;

    lbp_window_fetch_if #(.COL_BITS(3), .ROW_BITS(2), .DATA_W(8)) ifa ();
    lbp_window_fetch_if #(.COL_BITS(2), .ROW_BITS(3), .DATA_W(8)) ifb ();

    lbp_window_fetch #(.COL_BITS(3), .ROW_BITS(2), .DATA_W(8), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    lbp_window_fetch #(.COL_BITS(2), .ROW_BITS(3), .DATA_W(8), .MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifa.start_i     = start && (sel == 0);
    assign ifb.start_i     = start && (sel == 1);
    assign ifa.win_ready_i = ready && (sel == 0);
    assign ifb.win_ready_i = ready && (sel == 1);

    // Memory with a fixed one-cycle read latency.
    always @(posedge clk) begin
        ifa.gray_data_i <= mem[ifa.gray_addr_o];
        ifb.gray_data_i <= mem[ifb.gray_addr_o];
    end

    logic        o_req, o_valid, o_border, o_done;
    logic [4:0]  o_addr, o_pix;
    logic [7:0]  o_center;
    logic [63:0] o_nbr;

    always_comb begin
        o_req    = (sel == 1) ? ifb.gray_req_o  : ifa.gray_req_o;
        o_addr   = (sel == 1) ? ifb.gray_addr_o : ifa.gray_addr_o;
        o_valid  = (sel == 1) ? ifb.win_valid_o : ifa.win_valid_o;
        o_center = (sel == 1) ? ifb.center_o    : ifa.center_o;
        o_nbr    = (sel == 1) ? ifb.nbr_o       : ifa.nbr_o;
        o_pix    = (sel == 1) ? ifb.pix_addr_o  : ifa.pix_addr_o;
        o_border = (sel == 1) ? ifb.border_o    : ifa.border_o;
        o_done   = (sel == 1) ? ifb.done_o      : ifa.done_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    64'(o_req),    0);
        chk({tag, "_addr"},   64'(o_addr),   0);
        chk({tag, "_valid"},  64'(o_valid),  0);
        chk({tag, "_center"}, 64'(o_center), 0);
        chk({tag, "_nbr"},    o_nbr,         0);
        chk({tag, "_pix"},    64'(o_pix),    0);
        chk({tag, "_border"}, 64'(o_border), 0);
        chk({tag, "_done"},   64'(o_done),   0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    endtask

    // One full scan of the selected instance, checked window by window.
    task automatic run_scan(input int s, input bit stalls, input bit noise);
        int w, h, npix, row, col, ne, nreq, gap, stall, a, exp_gap;
        bit brd;
        int exp_addr [9];
        logic [7:0]  exp_c;
        logic [63:0] exp_n;
        sel   = s;
        w     = (s == 1) ? 4 : 8;
        npix  = 32;
        h     = npix / w;
        fill_mem();
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int p = 0; p < npix; p++) begin
            row   = p / w;
            col   = p % w;
            brd   = (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
            exp_c = '0;
            exp_n = '0;
            ne    = 0;
            if (!brd) begin
                exp_addr[0] = p;
                ne          = 1;
                exp_c       = mem[p];
                for (int n = 0; n < 8; n++) begin
                    if (s == 0 || dr[n] == 0 || dc[n] == 0) begin
                        a              = (row + dr[n]) * w + col + dc[n];
                        exp_addr[ne]   = a;
                        ne++;
                        exp_n[n*8 +: 8] = mem[a];
                    end
                end
            end
            exp_gap = brd ? 1 : ((s == 1) ? 7 : 11);
            stall   = stalls ? int'($urandom_range(0, 4)) : 0;
            ready   = (stall == 0);
            gap     = 0;
            nreq    = 0;
            while (!o_valid && gap < 40) begin
                if (o_req) begin
                    if (nreq < ne) chk("req_addr", 64'(o_addr), 64'(exp_addr[nreq]));
                    nreq++;
                end
                if (noise) start = ($urandom_range(0, 4) == 0);
                gap++;
                @(negedge clk);
            end
            start = 1'b0;
            chk("latency",   64'(gap),      64'(exp_gap));
            chk("req_count", 64'(nreq),     64'(ne));
            chk("pix_addr",  64'(o_pix),    64'(p));
            chk("border",    64'(o_border), 64'(brd));
            chk("center",    64'(o_center), 64'(exp_c));
            chk("nbr",       o_nbr,         exp_n);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("stall_valid",  64'(o_valid),  1);
                chk("stall_req",    64'(o_req),    0);
                chk("stall_pix",    64'(o_pix),    64'(p));
                chk("stall_center", 64'(o_center), 64'(exp_c));
                chk("stall_nbr",    o_nbr,         exp_n);
                if (noise) start = ($urandom_range(0, 2) == 0);
            end
            start = 1'b0;
            ready = 1'b1;
            @(negedge clk);
            chk("valid_drop", 64'(o_valid), 0);
            chk("done_at_end", 64'(o_done), 64'(p == npix - 1));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_quiet", {61'd0, o_req, o_valid, o_done}, 0);
        end
    endtask

    task automatic reset_mid_scan();
        bit seen;
        sel   = 0;
        ready = 1'b1;
        fill_mem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (o_req) seen = 1'b1;
            else @(negedge clk);
        end
        chk("reach_fetch", 64'(seen), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after_rst_quiet", {61'd0, o_req, o_valid, o_done}, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        sel   = 0;
        fill_mem();
        repeat (2) @(negedge clk);
        chk_all_zero("rst_a");
        sel = 1;
        #1;
        chk_all_zero("rst_b");
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(0, 1'b0, 1'b0);
        run_scan(0, 1'b1, 1'b1);
        run_scan(1, 1'b0, 1'b0);
        run_scan(1, 1'b1, 1'b1);
        reset_mid_scan();
        run_scan(0, 1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
